// File: rtl/bird_io_ctrl.sv
// bird_io_ctrl -- memory-mapped I/O block on the bird CPU bus.
//
// Decodes a 16-word window at BASE and provides an output port, a
// synchronised input port, an optional prescaled timer with a sticky
// compare flag, and a transmit FIFO drained over a valid/ready stream.
//
// Optional feature macro: BIRD_IO_TIMER_EN (timer, prescaler, CMP, match).
//
// Parameters:
//   BASE     - window base address, bits [15:4] compared
//   PRESCALE - timer ticks once every PRESCALE clocks (1..65535)
//   FIFO_AW  - TX FIFO depth is 2**FIFO_AW entries (1..7)
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   address, data_out - CPU bus address and write data
//   memwt             - CPU write strobe (qualified by hit)
//   hit, rdata        - combinational window decode and read data
//   in_port           - asynchronous external input
//   out_port          - output register
//   tx_data, tx_valid - FIFO head and not-empty
//   tx_ready          - consumer accepts head when tx_valid & tx_ready
module bird_io_ctrl #(
  parameter logic [15:0] BASE     = 16'hFF00,
  parameter int          PRESCALE = 1,
  parameter int          FIFO_AW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  input  logic        memwt,
  output logic        hit,
  output logic [15:0] rdata,
  input  logic [15:0] in_port,
  output logic [15:0] out_port,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [3:0] OFF_OUT    = 4'h0;
  localparam logic [3:0] OFF_IN     = 4'h1;
  localparam logic [3:0] OFF_TIMER  = 4'h2;
  localparam logic [3:0] OFF_CMP    = 4'h3;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_TXDATA = 4'h5;
  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
  localparam logic [FIFO_AW:0]   LVL_ONE = 1;

  logic [3:0]  offset;
  logic        wr;
  logic [15:0] in_sync_p0;
  logic [15:0] in_sync_p1;
  logic        overflow;
  logic        match;

  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               full;
  logic               empty;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               ovf_set;

  assign hit    = (address[15:4] == BASE[15:4]);
  assign offset = address[3:0];
  // A write in a reset cycle is ignored.
  assign wr     = memwt & hit & ~rst;

  // Output port
  always_ff @(posedge clk) begin
    if (rst)
      out_port <= '0;
    else if (wr && offset == OFF_OUT)
      out_port <= data_out;
  end

  // Input synchroniser: stage p0 catches the async input, p1 is the
  // metastability-settled value seen by the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_sync_p0 <= '0;
      in_sync_p1 <= '0;
    end else begin
      in_sync_p0 <= in_port;
      in_sync_p1 <= in_sync_p0;
    end
  end

`ifdef BIRD_IO_TIMER_EN
  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc_cnt;
  logic [15:0] count;
  logic [15:0] cmp;
  logic        tick;
  logic        wr_timer;
  logic        match_set;

  assign tick      = (presc_cnt == PRESC_MAX);
  assign wr_timer  = wr && offset == OFF_TIMER;
  // A TIMER write takes precedence over a tick in the same cycle, so
  // the suppressed tick cannot raise match either.
  assign match_set = tick && !wr_timer && (count == cmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      count     <= '0;
      cmp       <= 16'hFFFF;
      match     <= 1'b0;
    end else begin
      presc_cnt <= tick ? 16'h0000 : presc_cnt + 16'h0001;
      if (wr_timer)
        count <= data_out;
      else if (tick)
        count <= (count == cmp) ? 16'h0000 : count + 16'h0001;
      if (wr && offset == OFF_CMP)
        cmp <= data_out;
      // Set beats a same-cycle write-1-to-clear.
      if (match_set)
        match <= 1'b1;
      else if (wr && offset == OFF_STATUS && data_out[0])
        match <= 1'b0;
    end
  end
`else
  assign match = 1'b0;
`endif

  // TX FIFO
  assign full     = level[FIFO_AW];
  assign empty    = (level == '0);
  assign tx_valid = ~empty;
  assign tx_data  = empty ? 16'h0000 : mem[rd_ptr];
  assign pop      = tx_valid & tx_ready;
  assign push_req = wr && offset == OFF_TXDATA;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)
        level <= level + LVL_ONE;
      else if (pop && !push)
        level <= level - LVL_ONE;
      if (ovf_set)
        overflow <= 1'b1;
      else if (wr && offset == OFF_STATUS && data_out[3])
        overflow <= 1'b0;
    end
  end

  // Read mux: combinational and free of side effects.
  always_comb begin
    rdata = 16'h0000;
    if (hit) begin
      case (offset)
        OFF_OUT:    rdata = out_port;
        OFF_IN:     rdata = in_sync_p1;
`ifdef BIRD_IO_TIMER_EN
        OFF_TIMER:  rdata = count;
        OFF_CMP:    rdata = cmp;
`endif
        OFF_STATUS: rdata = {8'(level), 4'b0000, overflow, empty, full, match};
        default:    rdata = 16'h0000;
      endcase
    end
  end

endmodule
